// File: rtl/cv32e40p_clk_en_pkg.sv
// Shared types and widths for the core clock-enable controller.
// Stats widths are only used when CV32E40P_CLK_EN_STATS_EN is defined.
package cv32e40p_clk_en_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } clk_en_state_e;

  localparam int unsigned CLK_EN_CNT_W   = 8;
  localparam int unsigned CLK_EN_STATS_W = 32;

endpackage

// File: rtl/cv32e40p_clk_en_stat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module cv32e40p_clk_en_stat_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_clk_en_ctrl.sv
// Clock-enable controller for the core clock gate, running on the free clock.
// Optional gated-cycle statistics are enabled with CV32E40P_CLK_EN_STATS_EN.
module cv32e40p_clk_en_ctrl
  import cv32e40p_clk_en_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sleep_req_i,
  input  logic        core_busy_i,
  input  logic        bus_busy_i,
  input  logic        wake_i,
  input  logic        debug_req_i,
`ifdef CV32E40P_CLK_EN_STATS_EN
  input  logic        stats_clr_i,
  output logic [CLK_EN_STATS_W-1:0] gated_cycles_o,
`endif
  output logic        clk_en_o,
  output logic        core_sleep_o
);

  if (IDLE_CYCLES > 255) begin : g_bad_idle
    $error("IDLE_CYCLES must be in 0..255");
  end
  if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 255)) begin : g_bad_wake
    $error("WAKE_CYCLES must be in 1..255");
  end

  localparam logic [CLK_EN_CNT_W-1:0] IDLE_LAST = CLK_EN_CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CLK_EN_CNT_W-1:0] WAKE_LAST = CLK_EN_CNT_W'(WAKE_CYCLES - 1);

  clk_en_state_e           state_q, state_d;
  logic [CLK_EN_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CLK_EN_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                    clk_en_q, core_sleep_q;
  logic                    idle, wk;

  assign idle = sleep_req_i & ~core_busy_i & ~bus_busy_i & ~wake_i & ~debug_req_i;
  assign wk   = wake_i | debug_req_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      RUN: begin
        idle_cnt_d = '0;
        if (idle) begin
          state_d = (IDLE_CYCLES == 0) ? GATED : IDLE_WAIT;
        end
      end
      IDLE_WAIT: begin
        if (!idle) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      GATED: begin
        if (wk) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // Fixed-length settle window; further wake events cannot stretch it.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = RUN;
        end else begin
          wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are registered from the next state so they change only on the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      clk_en_q     <= 1'b1;
      core_sleep_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      clk_en_q     <= (state_d != GATED);
      core_sleep_q <= (state_d == GATED) || (state_d == WAKE);
    end
  end

  assign clk_en_o     = clk_en_q;
  assign core_sleep_o = core_sleep_q;

`ifdef CV32E40P_CLK_EN_STATS_EN
  cv32e40p_clk_en_stat_cnt #(
    .WIDTH (CLK_EN_STATS_W)
  ) u_stats (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stats_clr_i),
    .inc_i (~clk_en_q),
    .cnt_o (gated_cycles_o)
  );
`endif

endmodule
